// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and port ids shared by the memory port arbiter
package mem_arb_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way grant between the IF and DM requesters
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_if,
  input  logic req_dm,
  input  logic last_grant,
  input  logic prio,
  output logic grant,
  output logic valid
);
  always_comb begin
    valid = req_if | req_dm;
    grant = (req_if && req_dm) ? (prio ? PORT_DM : ~last_grant) : (req_dm ? PORT_DM : PORT_IF);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the IF and DM ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  logic [1:0]       state, state_nxt;
  logic             port_q, we_q, last_grant, pick_grant, pick_valid;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0] cnt;

  mem_arb_pick u_pick (
    .req_if    (if_req),
    .req_dm    (dm_req),
    .last_grant(last_grant),
    .prio      (DATA_PRIORITY != 0),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  always_comb begin
    state_nxt = state == IDLE  ? (pick_valid ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? (cnt == '0 ? DONE : WAIT) : IDLE;
    mem_en    = state == ISSUE;
    mem_we    = mem_en & we_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    if_ready  = state == DONE && port_q == PORT_IF;
    dm_ready  = state == DONE && port_q == PORT_DM;
    busy      = state != IDLE;
  end

  // Async reset aborts any transaction in flight; its ready never pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      last_grant <= PORT_DM;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        port_q  <= pick_grant;
        we_q    <= pick_grant == PORT_DM && dm_we;
        addr_q  <= pick_grant == PORT_DM ? dm_addr : if_addr;
        wdata_q <= pick_grant == PORT_DM ? dm_wdata : '0;
      end
      cnt <= state == ISSUE ? CNT_W'(MEM_LATENCY - 1) :
             (state == WAIT && cnt != '0) ? cnt - CNT_W'(1) : cnt;
      if (state == WAIT && cnt == '0 && !we_q) begin
        if (port_q == PORT_DM) dm_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
      if (state == DONE) last_grant <= port_q;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (LAT=1 DM-priority, LAT=3 round-robin) with a ready scoreboard
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          dut;
    logic        port;
    logic        chk;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  sb_t sbq[$];

  logic        clock = 1'b0;
  logic [1:0]  reset, if_req, dm_req, dm_we, if_ready, dm_ready, mem_en, mem_we, busy;
  logic [11:0] if_addr [2];
  logic [11:0] dm_addr [2];
  logic [11:0] mem_addr [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] if_rdata [2];
  logic [31:0] dm_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  int cyc = 0, checks = 0, errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] preload(logic [11:0] a);
    case (a)
      12'h010: preload = 32'hDEADBEEF;
      12'h011: preload = 32'h01234567;
      12'h012: preload = 32'h89ABCDEF;
      12'h030: preload = 32'h11112222;
      12'h040: preload = 32'hA0A0A0A0;
      12'h041: preload = 32'hB1B1B1B1;
      12'h042: preload = 32'hC2C2C2C2;
      12'h043: preload = 32'hD3D3D3D3;
      12'h050: preload = 32'h55AA55AA;
      default: preload = {20'h0, a};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int LAT = g == 0 ? 1 : 3;
    logic [31:0] mem [4096];
    logic        written [4096];
    logic [31:0] pipe [3];
    logic [31:0] got;
    sb_t         e;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .DATA_PRIORITY(g == 0 ? 1 : 0)) dut (
      .clock    (clock),
      .reset    (reset[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ready (if_ready[g]),
      .if_rdata (if_rdata[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_ready (dm_ready[g]),
      .dm_rdata (dm_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );

    // Memory model: read data appears LAT cycles after the mem_en cycle, zero otherwise.
    always @(posedge clock) begin
      if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]]     <= mem_wdata[g];
        written[mem_addr[g]] <= 1'b1;
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ?
                 (written[mem_addr[g]] ? mem[mem_addr[g]] : preload(mem_addr[g])) : 32'h0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    always @(negedge clock) begin
      checks++;
      if ((if_ready[g] && dm_ready[g]) ||
          (!mem_en[g] && (mem_we[g] || mem_addr[g] != 0 || mem_wdata[g] != 0))) begin
        errors++;
        $display("FAIL invariant dut%0d: got if_ready=%b dm_ready=%b mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h, required one ready at most and zero bus while idle",
                 g, if_ready[g], dm_ready[g], mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g]);
      end
    end

    always @(negedge clock) if (if_ready[g] || dm_ready[g]) begin
      checks++;
      got = dm_ready[g] ? dm_rdata[g] : if_rdata[g];
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready dut%0d: got if_ready=%b dm_ready=%b at cycle %0d, required no ready",
                 g, if_ready[g], dm_ready[g], cyc);
      end else begin
        e = sbq.pop_front();
        if (e.dut != g || e.port != dm_ready[g] || e.cyc != cyc || (e.chk && got != e.data)) begin
          errors++;
          $display("FAIL ready_txn dut%0d: got port=%0d data=%h cycle=%0d, required dut%0d port=%0d data=%h cycle=%0d",
                   g, dm_ready[g], got, cyc, e.dut, e.port, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(int g, logic port);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (port ? dm_ready[g] : if_ready[g]) return;
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout dut%0d port%0d: got no ready in 40 cycles, required a ready pulse", g, port);
  endtask

  // Uncontended transaction: strobe one cycle after the request, ready LAT+2 cycles after it.
  task automatic txn(int g, logic port, logic we, logic [11:0] a, logic [31:0] wd, logic [31:0] rd);
    int lat = g == 0 ? 1 : 3;
    @(posedge clock); #1;
    sbq.push_back('{g, port, !we, rd, cyc + lat + 2});
    if (port) begin
      dm_req[g] = 1'b1; dm_we[g] = we; dm_addr[g] = a; dm_wdata[g] = wd;
    end else begin
      if_req[g] = 1'b1; if_addr[g] = a;
    end
    @(negedge clock);
    @(negedge clock);
    chk("issue_strobe", 32'({mem_en[g], mem_we[g], mem_addr[g]}), 32'({1'b1, we, a}));
    if (we) chk("issue_wdata", mem_wdata[g], wd);
    wait_ready(g, port);
    @(posedge clock); #1;
    if (port) dm_req[g] = 1'b0;
    else if_req[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc;
    logic [31:0] exp4 [4];
    int k, n;
    exp4 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    reset = 2'b11; if_req = '0; dm_req = '0; dm_we = '0;
    for (int i = 0; i < 2; i++) begin
      if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 2'b00;

    // idle after reset
    chk("reset_busy", 32'(busy), 32'h0);
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      acc = acc | 32'({mem_en, mem_we, busy, if_ready, dm_ready}) | 32'(mem_addr[0]) | 32'(mem_addr[1]) |
            mem_wdata[0] | mem_wdata[1] | if_rdata[0] | if_rdata[1] | dm_rdata[0] | dm_rdata[1];
    end
    chk("idle_20_cycles_outputs", acc, 32'h0);

    // IF read, LAT=1
    txn(0, PORT_IF, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF);
    @(negedge clock);
    chk("if_rdata_hold", if_rdata[0], 32'hDEADBEEF);

    // DM read, write, read back
    txn(0, PORT_DM, 1'b0, 12'h030, 32'h0, 32'h11112222);
    txn(0, PORT_DM, 1'b1, 12'h020, 32'h0CAFEF00, 32'h0);
    @(negedge clock);
    chk("dm_rdata_after_write", dm_rdata[0], 32'h11112222);
    txn(0, PORT_DM, 1'b0, 12'h020, 32'h0, 32'h0CAFEF00);
    chk("if_rdata_after_dm", if_rdata[0], 32'hDEADBEEF);

    // DM priority: IF held the whole time and never served
    @(posedge clock); #1;
    k = cyc;
    for (int i = 0; i < 4; i++) sbq.push_back('{0, PORT_DM, 1'b1, exp4[i], k + 3 + 4 * i});
    if_req[0] = 1'b1; if_addr[0] = 12'h011; dm_we[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_addr[0] = 12'h040 + 12'(i);
      dm_req[0] = 1'b1;
      wait_ready(0, PORT_DM);
      @(posedge clock); #1;
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    chk("prio_if_starved_rdata", if_rdata[0], 32'hDEADBEEF);

    // round-robin on LAT=3: IF, DM, IF, DM
    @(posedge clock); #1;
    k = cyc;
    sbq.push_back('{1, PORT_IF, 1'b1, 32'hDEADBEEF, k + 5});
    sbq.push_back('{1, PORT_DM, 1'b1, 32'hA0A0A0A0, k + 11});
    sbq.push_back('{1, PORT_IF, 1'b1, 32'h01234567, k + 17});
    sbq.push_back('{1, PORT_DM, 1'b1, 32'hB1B1B1B1, k + 23});
    dm_we[1] = 1'b0;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          if_addr[1] = 12'h010 + 12'(i);
          if_req[1] = 1'b1;
          wait_ready(1, PORT_IF);
          @(posedge clock); #1;
        end
        if_req[1] = 1'b0;
      end
      begin
        for (int j = 0; j < 2; j++) begin
          dm_addr[1] = 12'h040 + 12'(j);
          dm_req[1] = 1'b1;
          wait_ready(1, PORT_DM);
          @(posedge clock); #1;
        end
        dm_req[1] = 1'b0;
      end
    join

    // reset during WAIT aborts the transaction
    @(posedge clock); #1;
    if_addr[1] = 12'h012; if_req[1] = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_pre_busy", 32'(busy[1]), 32'h1);
    reset[1] = 1'b1;
    #1;
    chk("abort_busy", 32'(busy[1]), 32'h0);
    chk("abort_mem_en", 32'(mem_en[1]), 32'h0);
    if_req[1] = 1'b0;
    @(posedge clock); #1;
    reset[1] = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clock);
      n += int'(if_ready[1]) + int'(dm_ready[1]);
    end
    chk("abort_no_ready", 32'(n), 32'h0);
    chk("abort_if_rdata", if_rdata[1], 32'h0);
    txn(1, PORT_IF, 1'b0, 12'h012, 32'h0, 32'h89ABCDEF);

    // DM request dropped right after grant still completes
    @(posedge clock); #1;
    sbq.push_back('{0, PORT_DM, 1'b1, 32'h55AA55AA, cyc + 3});
    dm_we[0] = 1'b0; dm_addr[0] = 12'h050; dm_req[0] = 1'b1;
    @(posedge clock); #1;
    dm_req[0] = 1'b0;
    wait_ready(0, PORT_DM);
    @(negedge clock);
    chk("drop_then_idle", 32'(busy[0]), 32'h0);
    acc = '0;
    repeat (5) begin
      @(negedge clock);
      acc = acc | 32'({mem_en[0], busy[0]});
    end
    chk("drop_no_reissue", acc, 32'h0);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
